// File: rtl/btb_update_queue.sv
// btb_update_queue: write-side companion of the branch target buffer.
// Resolved-branch records arrive from the backend, records that would not
// change the BTB are dropped, and the rest are buffered in a small FIFO that
// drains one entry per cycle into the BTB write port.
// Optional build macro: BTB_UPD_DEDUP_EN merges a record into the most recently
// pushed queued entry when both carry the same PC.
module btb_update_queue #(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 upd_valid_i,
    output logic                 upd_ready_o,
    input  logic [29:0]          upd_pc_i,
    input  logic                 upd_taken_i,
    input  logic [29:0]          upd_bta_i,
    input  logic [1:0]           upd_br_type_i,
    input  logic                 upd_btb_miss_i,
    input  logic [29:0]          upd_pred_bta_i,
    input  logic                 wr_block_i,
    output logic                 btb_we_o,
    output logic [29:0]          btb_wpc_o,
    output logic [29:0]          btb_bta_o,
    output logic [1:0]           btb_br_type_o,
    output logic [CNT_WIDTH-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    logic [29:0]          pc_mem   [DEPTH];
    logic [29:0]          bta_mem  [DEPTH];
    logic [1:0]           type_mem [DEPTH];
    logic [PTR_W-1:0]     head_q;
    logic [PTR_W-1:0]     tail_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 accept;
    logic                 qualify;
    logic                 pop;
    logic                 push;
    logic                 dedup_hit;

    // Handshake: a record transfers on any edge where upd_valid_i and
    // upd_ready_o are both high; the producer holds its record stable until
    // then. Ready depends only on registered occupancy, so a full queue refuses
    // even if it pops on that same edge.
    assign upd_ready_o = (count_q != FULL_CNT);
    assign accept      = upd_valid_i & upd_ready_o;
    // Only taken branches that missed or mispredicted the target need a write.
    assign qualify     = accept & upd_taken_i &
                         (upd_btb_miss_i | (upd_pred_bta_i != upd_bta_i));

    // The drain side is combinational from the head entry.
    assign btb_we_o      = (count_q != '0) & ~wr_block_i;
    assign btb_wpc_o     = pc_mem[head_q];
    assign btb_bta_o     = bta_mem[head_q];
    assign btb_br_type_o = type_mem[head_q];
    assign pop           = btb_we_o;
    assign count_o       = count_q;

`ifdef BTB_UPD_DEDUP_EN
    logic [PTR_W-1:0] last_idx;

    // Newest queued entry sits just behind the tail; it is only safe to edit
    // if it is not the head being written out on this same edge.
    always_comb begin
        last_idx  = tail_q - PTR_W'(1);
        dedup_hit = qualify & (count_q != '0) &
                    ~(pop & (count_q == CNT_WIDTH'(1))) &
                    (pc_mem[last_idx] == upd_pc_i);
    end
`else
    assign dedup_hit = 1'b0;
`endif

    assign push = qualify & ~dedup_hit;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop)  head_q <= head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_WIDTH'(1);
                2'b01:   count_q <= count_q - CNT_WIDTH'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage: full write at the tail, or an in-place target update.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]   <= upd_pc_i;
            bta_mem[tail_q]  <= upd_bta_i;
            type_mem[tail_q] <= upd_br_type_i;
        end
`ifdef BTB_UPD_DEDUP_EN
        else if (dedup_hit) begin
            bta_mem[last_idx]  <= upd_bta_i;
            type_mem[last_idx] <= upd_br_type_i;
        end
`endif
    end

endmodule

// File: tb/tb_btb_update_queue.sv
// Self-checking bench for btb_update_queue (DEPTH=4). Directed vectors plus a
// per-cycle reference model of the queue contents. Expectations follow the
// BTB_UPD_DEDUP_EN macro when it is defined for the build.
module tb_btb_update_queue;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk;
    logic          reset;
    logic          upd_valid_i;
    logic          upd_ready_o;
    logic [29:0]   upd_pc_i;
    logic          upd_taken_i;
    logic [29:0]   upd_bta_i;
    logic [1:0]    upd_br_type_i;
    logic          upd_btb_miss_i;
    logic [29:0]   upd_pred_bta_i;
    logic          wr_block_i;
    logic          btb_we_o;
    logic [29:0]   btb_wpc_o;
    logic [29:0]   btb_bta_o;
    logic [1:0]    btb_br_type_o;
    logic [CW-1:0] count_o;

    int errors = 0;
    int checks = 0;
    int writes = 0;
    logic [61:0] exp_q[$];

    btb_update_queue #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .upd_valid_i    (upd_valid_i),
        .upd_ready_o    (upd_ready_o),
        .upd_pc_i       (upd_pc_i),
        .upd_taken_i    (upd_taken_i),
        .upd_bta_i      (upd_bta_i),
        .upd_br_type_i  (upd_br_type_i),
        .upd_btb_miss_i (upd_btb_miss_i),
        .upd_pred_bta_i (upd_pred_bta_i),
        .wr_block_i     (wr_block_i),
        .btb_we_o       (btb_we_o),
        .btb_wpc_o      (btb_wpc_o),
        .btb_bta_o      (btb_bta_o),
        .btb_br_type_o  (btb_br_type_o),
        .count_o        (count_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic qual(input logic taken, input logic miss,
                                  input logic [29:0] pred, input logic [29:0] bta);
        return taken && (miss || pred != bta);
    endfunction

    // Driver tasks: inputs change only just after a falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic [29:0] pc, input logic [29:0] bta, input logic [1:0] ty,
                         input logic taken, input logic miss, input logic [29:0] pred);
        upd_valid_i    = 1'b1;
        upd_pc_i       = pc;
        upd_bta_i      = bta;
        upd_br_type_i  = ty;
        upd_taken_i    = taken;
        upd_btb_miss_i = miss;
        upd_pred_bta_i = pred;
    endtask

    task automatic push_rec(input logic [29:0] pc, input logic [29:0] bta, input logic [1:0] ty);
        drive(pc, bta, ty, 1'b1, 1'b1, 30'h0);
    endtask

    task automatic idle();
        upd_valid_i = 1'b0;
    endtask

    // Scoreboard: reference model of queue contents, checked every cycle
    // between the falling edge and the next rising edge.
    logic [61:0] head_rec;
    logic [61:0] new_rec;
    logic        m_pop;
    logic        m_acc;
    always @(negedge clk) begin
        #2;
        if (reset) begin
            exp_q.delete();
        end else begin
            check("count", 64'(count_o), 64'(exp_q.size()));
            check("ready", 64'(upd_ready_o), 64'(exp_q.size() != DEPTH));
            m_pop = (exp_q.size() != 0) && !wr_block_i;
            m_acc = upd_valid_i && (exp_q.size() != DEPTH);
            check("we", 64'(btb_we_o), 64'(m_pop));
            if (m_pop) begin
                head_rec = exp_q.pop_front();
                if (btb_we_o)
                    check("write", 64'({btb_wpc_o, btb_bta_o, btb_br_type_o}), 64'(head_rec));
                writes++;
            end
            if (m_acc && qual(upd_taken_i, upd_btb_miss_i, upd_pred_bta_i, upd_bta_i)) begin
                new_rec = {upd_pc_i, upd_bta_i, upd_br_type_i};
`ifdef BTB_UPD_DEDUP_EN
                if (exp_q.size() != 0 && exp_q[exp_q.size()-1][61:32] == upd_pc_i)
                    exp_q[exp_q.size()-1] = new_rec;
                else
                    exp_q.push_back(new_rec);
`else
                exp_q.push_back(new_rec);
`endif
            end
        end
    end

    int w0;
    initial begin
        reset = 1'b1;
        wr_block_i = 1'b0;
        upd_valid_i = 1'b0;
        upd_pc_i = '0; upd_bta_i = '0; upd_br_type_i = '0;
        upd_taken_i = 1'b0; upd_btb_miss_i = 1'b0; upd_pred_bta_i = '0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        tick(); #1;
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_we", 64'(btb_we_o), 64'd0);
        check("rst_ready", 64'(upd_ready_o), 64'd1);

        // Single push, one-cycle latency to the write port
        tick(); push_rec(30'h0000100, 30'h0000200, 2'b01);
        tick(); idle(); #1;
        check("lat_we", 64'(btb_we_o), 64'd1);
        check("lat_wpc", 64'(btb_wpc_o), 64'h0000100);
        check("lat_bta", 64'(btb_bta_o), 64'h0000200);
        check("lat_type", 64'(btb_br_type_o), 64'd1);
        tick(); #1;
        check("lat_we_off", 64'(btb_we_o), 64'd0);

        // Filtering
        tick(); drive(30'h0000110, 30'h0000300, 2'b00, 1'b0, 1'b1, 30'h0);
        tick(); idle(); #1;
        check("drop_not_taken", 64'(count_o), 64'd0);
        tick(); drive(30'h0000120, 30'h0000300, 2'b00, 1'b1, 1'b0, 30'h0000300);
        tick(); idle(); #1;
        check("drop_correct_pred", 64'(count_o), 64'd0);
        tick(); drive(30'h0000130, 30'h0000300, 2'b10, 1'b1, 1'b0, 30'h0000304);
        tick(); idle(); #1;
        check("push_mispred_we", 64'(btb_we_o), 64'd1);
        check("push_mispred_pc", 64'(btb_wpc_o), 64'h0000130);
        tick(); tick();

        // Blocked write port: fill to DEPTH, fifth record held off
        wr_block_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_rec(30'h0001000 + 30'(i), 30'h0002000 + 30'(i), 2'(i));
            tick();
        end
        push_rec(30'h0001004, 30'h0002004, 2'b11); #1;
        check("full_count", 64'(count_o), 64'd4);
        check("full_ready", 64'(upd_ready_o), 64'd0);
        tick(); #1;
        check("full_hold_count", 64'(count_o), 64'd4);
        tick(); wr_block_i = 1'b0; #1;
        check("no_bypass_ready", 64'(upd_ready_o), 64'd0);
        check("release_wpc", 64'(btb_wpc_o), 64'h0001000);
        tick(); #1;
        check("fifth_ready", 64'(upd_ready_o), 64'd1);
        tick(); idle();
        for (int i = 0; i < 6; i++) tick();
        #1;
        check("full_drained", 64'(count_o), 64'd0);

        // Steady occupancy of 2 with simultaneous push/pop across wrap
        wr_block_i = 1'b1;
        push_rec(30'h0003000, 30'h0004000, 2'b01);
        tick(); push_rec(30'h0003001, 30'h0004001, 2'b10);
        tick(); wr_block_i = 1'b0;
        for (int i = 2; i < 8; i++) begin
            push_rec(30'h0003000 + 30'(i), 30'h0004000 + 30'(i), 2'(i));
            #1;
            check("steady_count", 64'(count_o), 64'd2);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) tick();

        // Reset overrides a same-cycle push
        wr_block_i = 1'b1;
        push_rec(30'h0005000, 30'h0006000, 2'b01);
        tick(); reset = 1'b1; push_rec(30'h0005001, 30'h0006001, 2'b01);
        tick(); reset = 1'b0; idle(); #1;
        check("rst_ovr_count", 64'(count_o), 64'd0);
        check("rst_ovr_ready", 64'(upd_ready_o), 64'd1);

        // Same-PC records back to back while blocked
        tick(); w0 = writes;
        push_rec(30'h0000040, 30'h0000080, 2'b10);
        tick(); push_rec(30'h0000040, 30'h00000C0, 2'b10);
        tick(); idle(); #1;
`ifdef BTB_UPD_DEDUP_EN
        check("dedup_count", 64'(count_o), 64'd1);
`else
        check("dedup_count", 64'(count_o), 64'd2);
`endif
        tick(); wr_block_i = 1'b0; #1;
`ifdef BTB_UPD_DEDUP_EN
        check("dedup_first_bta", 64'(btb_bta_o), 64'h00000C0);
`else
        check("dedup_first_bta", 64'(btb_bta_o), 64'h0000080);
`endif
        for (int i = 0; i < 4; i++) tick();
        #1;
`ifdef BTB_UPD_DEDUP_EN
        check("dedup_writes", 64'(writes - w0), 64'd1);
`else
        check("dedup_writes", 64'(writes - w0), 64'd2);
`endif
        check("final_empty", 64'(exp_q.size()), 64'd0);
        check("final_count", 64'(count_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
